// File: rtl/mux_sel_scheduler_pkg.sv
// Shared types and width helpers for the round-robin mux select scheduler.
// Pure definitions: no logic, no latency, no flow control.
package mux_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int MAX_NREQ = 8;
    localparam int MAX_SELW = 3;

    function automatic int sel_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // cnt only has to reach HOLD_CYC-1, but HOLD_CYC+1 keeps HOLD_CYC=1 at one bit
    function automatic int cnt_w(input int hold_cyc);
        return $clog2(hold_cyc + 1);
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_SELW-1:0] idx);
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Requester-side bundle of the mux select scheduler: requests/sources in, grant/select/stream out.
// Wires only; the master drives req/data_in, the scheduler drives everything else.
interface mux_sel_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4
);
    import mux_sched_pkg::*;

    localparam int SELW = sel_w(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data_in;
    logic [NREQ-1:0]    grant;
    logic [SELW-1:0]    sel;
    logic [DW-1:0]      g;
    logic               g_valid;
    logic               busy;

    modport master (
        output req, data_in,
        input  grant, sel, g, g_valid, busy
    );

    modport slave (
        input  req, data_in,
        output grant, sel, g, g_valid, busy
    );

endinterface

// File: rtl/mux_sel_scheduler_rr_pick.sv
// Circular priority picker: first set req bit at or after ptr, wrapping past NREQ-1.
// Purely combinational, zero latency, no flow control.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SELW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW-1:0] cand;

    // Scan farthest-first so the candidate closest to ptr overwrites the rest.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ptr + SELW'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin owner of a shared source mux with a bounded hold window; grant/sel registered.
// Grant 1 cycle after request, g/g_valid 1 cycle after grant; level requests, no backpressure.
module mux_sel_scheduler
    import mux_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    mux_sel_scheduler_if.slave  bus
);

    localparam int SELW = sel_w(NREQ);
    localparam int CNTW = cnt_w(HOLD_CYC);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [DW-1:0]   g_q;
    logic            g_valid_q;

    logic            rel;
    logic [SELW-1:0] pick_ptr;
    logic [SELW-1:0] pick_idx;
    logic            pick_found;

    assign rel      = !bus.req[sel_q] || (cnt_q == CNTW'(HOLD_CYC - 1));
    // On release the search restarts just past the old owner, giving a zero-bubble handover.
    assign pick_ptr = (state_q == OWN && rel) ? sel_q + SELW'(1) : ptr_q;

    rr_pick #(.NREQ(NREQ), .SELW(SELW)) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d = NREQ'(onehot(MAX_SELW'(pick_idx)));
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!rel) begin
                    cnt_d = cnt_q + CNTW'(1);
                end else begin
                    ptr_d = pick_ptr;
                    if (pick_found) begin
                        grant_d = NREQ'(onehot(MAX_SELW'(pick_idx)));
                        sel_d   = pick_idx;
                        cnt_d   = '0;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q       <= '0;
            g_valid_q <= 1'b0;
        end else begin
            g_q       <= bus.data_in[int'(sel_q) * DW +: DW];
            g_valid_q <= |grant_q;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.g       = g_q;
    assign bus.g_valid = g_valid_q;
    assign bus.busy    = (state_q == OWN);

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Scoreboard bench: stimulus drives on the falling edge and queues the model's prediction,
// a separate monitor pops and compares just after each rising edge.
module tb_mux_sel_scheduler;

    localparam int NREQ     = 4;
    localparam int DW       = 4;
    localparam int HOLD_CYC = 2;

    logic clk;
    logic rst;

    mux_sel_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    mux_sel_scheduler #(.NREQ(NREQ), .DW(DW), .HOLD_CYC(HOLD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       in_rst;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       gv;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] g_q[$];

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    bit stop     = 0;

    // Reference model: owner index (-1 = nobody), cycles owned so far, search start.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [15:0] d);
        exp_t e;
        int   p;
        e.in_rst = r;
        if (r) begin
            m_owner = -1;
            m_sel   = 0;
            m_ptr   = 0;
            m_held  = 0;
            e.gv    = 1'b0;
        end else begin
            e.gv = (m_owner >= 0);
            if (m_owner >= 0) g_q.push_back(d[m_sel*DW +: DW]);
            if (m_owner < 0) begin
                p = pick(rq, m_ptr);
                if (p >= 0) begin
                    m_owner = p; m_sel = p; m_held = 1;
                end
            end else if (rq[m_owner] && m_held < HOLD_CYC) begin
                m_held++;
            end else begin
                m_ptr = (m_owner + 1) % NREQ;
                p     = pick(rq, m_ptr);
                if (p >= 0) begin
                    m_owner = p; m_sel = p; m_held = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.sel   = 2'(m_sel);
        e.busy  = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] d);
        @(negedge clk);
        rst         = r;
        bus.req     = rq;
        bus.data_in = d;
        model_edge(r, rq, d);
        started = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (stop) break;
            if (exp_q.size() == 0) begin
                if (started) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("grant",   32'(bus.grant),   32'(e.grant));
                chk("sel",     32'(bus.sel),     32'(e.sel));
                chk("busy",    32'(bus.busy),    32'(e.busy));
                chk("g_valid", 32'(bus.g_valid), 32'(e.gv));
                if (e.in_rst) chk("g_reset", 32'(bus.g), 32'h0);
                if (bus.g_valid === 1'b1) begin
                    if (g_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL g_unexpected actual=%0h required=no_data at %0t", bus.g, $time);
                    end else begin
                        chk("g", 32'(bus.g), 32'(g_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rq;
        rst         = 1'b1;
        bus.req     = '0;
        bus.data_in = '0;

        // Reset held with everyone requesting
        step(1'b1, 4'b1111, 16'($urandom));
        step(1'b1, 4'b1111, 16'($urandom));

        // Sole requester: re-granted without a gap, g carries source 2
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0100, 16'h0500);
        // Release to idle
        step(1'b0, 4'b0000, 16'($urandom));
        step(1'b0, 4'b0000, 16'($urandom));

        // Full rotation from ptr=0
        step(1'b1, 4'b0000, 16'($urandom));
        for (int i = 0; i < 12; i++) step(1'b0, 4'b1111, 16'($urandom));

        // Early drop in first OWN cycle, then wrap back to 0 before 1
        step(1'b1, 4'b0000, 16'($urandom));
        step(1'b0, 4'b0010, 16'($urandom));
        step(1'b0, 4'b1000, 16'($urandom));
        step(1'b0, 4'b1000, 16'($urandom));
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 16'($urandom));

        // Reset mid-ownership, then pointer restarts at 0
        step(1'b1, 4'b0000, 16'($urandom));
        step(1'b0, 4'b0010, 16'($urandom));
        step(1'b1, 4'b1111, 16'($urandom));
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 16'($urandom));

        // Randomized: sticky requests with occasional toggles, rare resets
        rq = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            step(($urandom_range(0, 99) == 0), rq, 16'($urandom));
        end

        @(posedge clk);
        #2;
        stop = 1;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("g_queue_drained",   32'(g_q.size()),   32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
